// File: rtl/dcache_miss_handler_if.sv
// Memory-side word bus of the dcache miss handler.
// The master issues single-word requests, and the slave stalls them with dwait.
interface dcache_miss_handler_if;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] dload;
    logic        dwait;

    modport master (
        output dREN, dWEN, daddr, dstore,
        input  dload, dwait
    );

    modport slave (
        input  dREN, dWEN, daddr, dstore,
        output dload, dwait
    );
endinterface

// File: rtl/dcache_miss_handler.sv
// Two-word-block dcache miss handler: write back dirty victim, then refill.
// Optional halt flush walk of all 16 frames is enabled by DCACHE_HALT_FLUSH_EN.
module dcache_miss_handler (
    input  logic        CLK,
    input  logic        RST,
    input  logic        miss,
    input  logic [31:0] req_addr,
    input  logic        victim_way,
    input  logic        victim_valid,
    input  logic        victim_dirty,
    input  logic [25:0] victim_tag,
    input  logic [31:0] victim_word0,
    input  logic [31:0] victim_word1,
    dcache_miss_handler_if.master mem,
    output logic        fill_en,
    output logic        fill_way,
    output logic        fill_off,
    output logic [31:0] fill_data,
    output logic [25:0] fill_tag,
    output logic        tag_wen,
    output logic        busy,
    output logic        done,
    input  logic        halt,
    output logic [2:0]  flush_idx,
    output logic        flush_way,
    output logic        flushed
);

    typedef enum logic [3:0] {
        IDLE, WB0, WB1, FETCH0, FETCH1, DONE,
        FCHK, FWB0, FWB1, FLUSHED
    } state_t;

    state_t      state, nxt;
    logic [25:0] rtag, vtag;
    logic [2:0]  idx;
    logic        vway;
    logic [31:0] w0, w1;
    logic        xfer, start, vdirty;

    assign xfer   = !mem.dwait;
    assign vdirty = victim_valid && victim_dirty;

`ifdef DCACHE_HALT_FLUSH_EN
    logic [2:0] fidx;
    logic       fway;
    logic       last;
    logic       unused_bits;

    assign start       = (state == IDLE) && miss && !halt;
    assign last        = (fidx == 3'd7) && fway;
    assign unused_bits = ^req_addr[2:0];
`else
    logic unused_bits;

    assign start       = (state == IDLE) && miss;
    assign unused_bits = ^{req_addr[2:0], halt};
`endif

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= nxt;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rtag <= '0;
            vtag <= '0;
            idx  <= '0;
            vway <= 1'b0;
            w0   <= '0;
            w1   <= '0;
`ifdef DCACHE_HALT_FLUSH_EN
            fidx <= '0;
            fway <= 1'b0;
`endif
        end else begin
            if (start) begin
                rtag <= req_addr[31:6];
                idx  <= req_addr[5:3];
                vway <= victim_way;
                vtag <= victim_tag;
                w0   <= victim_word0;
                w1   <= victim_word1;
            end
`ifdef DCACHE_HALT_FLUSH_EN
            // flush frames reuse the victim latches for their write-back
            if (state == FCHK && vdirty) begin
                vtag <= victim_tag;
                w0   <= victim_word0;
                w1   <= victim_word1;
            end
            if ((state == FCHK && !vdirty) ||
                (state == FWB1 && xfer))
                {fidx, fway} <= {fidx, fway} + 4'd1;
`endif
        end
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE: begin
`ifdef DCACHE_HALT_FLUSH_EN
                if (halt) nxt = FCHK;
                else
`endif
                if (start) nxt = vdirty ? WB0 : FETCH0;
            end
            WB0:    if (xfer) nxt = WB1;
            WB1:    if (xfer) nxt = FETCH0;
            FETCH0: if (xfer) nxt = FETCH1;
            FETCH1: if (xfer) nxt = DONE;
            DONE:   nxt = IDLE;
`ifdef DCACHE_HALT_FLUSH_EN
            FCHK: begin
                if (vdirty)    nxt = FWB0;
                else if (last) nxt = FLUSHED;
            end
            FWB0: if (xfer) nxt = FWB1;
            FWB1: if (xfer) nxt = last ? FLUSHED : FCHK;
            FLUSHED: nxt = FLUSHED;
`endif
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        mem.dREN   = 1'b0;
        mem.dWEN   = 1'b0;
        mem.daddr  = '0;
        mem.dstore = '0;
        fill_en    = 1'b0;
        fill_way   = 1'b0;
        fill_off   = 1'b0;
        fill_data  = '0;
        fill_tag   = '0;
        tag_wen    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        flush_idx  = '0;
        flush_way  = 1'b0;
        flushed    = 1'b0;
        // reset masks everything so an abandoned fill never lands
        if (!RST) begin
            busy = (state != IDLE);
            unique case (state)
                WB0: begin
                    mem.dWEN   = 1'b1;
                    mem.daddr  = {vtag, idx, 3'b000};
                    mem.dstore = w0;
                end
                WB1: begin
                    mem.dWEN   = 1'b1;
                    mem.daddr  = {vtag, idx, 3'b100};
                    mem.dstore = w1;
                end
                FETCH0: begin
                    mem.dREN  = 1'b1;
                    mem.daddr = {rtag, idx, 3'b000};
                    if (xfer) begin
                        fill_en   = 1'b1;
                        fill_way  = vway;
                        fill_data = mem.dload;
                    end
                end
                FETCH1: begin
                    mem.dREN  = 1'b1;
                    mem.daddr = {rtag, idx, 3'b100};
                    if (xfer) begin
                        fill_en   = 1'b1;
                        fill_way  = vway;
                        fill_off  = 1'b1;
                        fill_data = mem.dload;
                    end
                end
                DONE: begin
                    tag_wen  = 1'b1;
                    fill_way = vway;
                    fill_tag = rtag;
                    done     = 1'b1;
                end
`ifdef DCACHE_HALT_FLUSH_EN
                FWB0: begin
                    mem.dWEN   = 1'b1;
                    mem.daddr  = {vtag, fidx, 3'b000};
                    mem.dstore = w0;
                end
                FWB1: begin
                    mem.dWEN   = 1'b1;
                    mem.daddr  = {vtag, fidx, 3'b100};
                    mem.dstore = w1;
                end
                FLUSHED: flushed = 1'b1;
`endif
                default: ;
            endcase
`ifdef DCACHE_HALT_FLUSH_EN
            flush_idx = fidx;
            flush_way = fway;
`endif
        end
    end

endmodule

// File: tb/tb_dcache_miss_handler.sv
// Scoreboard bench for dcache_miss_handler: bus/fill/tag events vs queue.
// A simple memory model stalls each transfer for a configurable number of cycles.
module tb_dcache_miss_handler;

    localparam logic [2:0] K_WR = 3'd1;
    localparam logic [2:0] K_RD = 3'd2;
    localparam logic [2:0] K_FL = 3'd3;
    localparam logic [2:0] K_TG = 3'd4;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        miss = 1'b0;
    logic        halt = 1'b0;
    logic [31:0] req_addr;
    logic        victim_way, victim_valid, victim_dirty;
    logic [25:0] victim_tag;
    logic [31:0] victim_word0, victim_word1;
    logic        fill_en, fill_way, fill_off, tag_wen;
    logic [31:0] fill_data;
    logic [25:0] fill_tag;
    logic        busy, done, flush_way, flushed;
    logic [2:0]  flush_idx;

    logic        drv_way = 1'b0, drv_valid = 1'b0, drv_dirty = 1'b0;
    logic [31:0] drv_addr = '0, drv_w0 = '0, drv_w1 = '0;
    logic [25:0] drv_tag = '0;
    logic        flush_mode = 1'b0;
    logic [31:0] load0 = '0, load1 = '0;
    int          wait_cycles = 0;
    int          wcnt = 0;

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;
    logic [68:0] sbq[$];

    dcache_miss_handler_if mem();

    function automatic logic fr_dirty(input logic [2:0] i, input logic w);
        return (i == 3'd2 && w) || (i == 3'd5 && !w);
    endfunction
    function automatic logic [25:0] fr_tag(input logic [2:0] i, input logic w);
        return {22'h100, i, w};
    endfunction
    function automatic logic [31:0] fr_w0(input logic [2:0] i, input logic w);
        return {24'hF00000, 4'h0, i, w};
    endfunction

    assign req_addr     = drv_addr;
    assign victim_way   = flush_mode ? flush_way : drv_way;
    assign victim_valid = flush_mode ? 1'b1 : drv_valid;
    assign victim_dirty = flush_mode ? fr_dirty(flush_idx, flush_way) : drv_dirty;
    assign victim_tag   = flush_mode ? fr_tag(flush_idx, flush_way) : drv_tag;
    assign victim_word0 = flush_mode ? fr_w0(flush_idx, flush_way) : drv_w0;
    assign victim_word1 = flush_mode ? ~fr_w0(flush_idx, flush_way) : drv_w1;
    assign mem.dload    = mem.daddr[2] ? load1 : load0;

    dcache_miss_handler dut (
        .CLK(CLK), .RST(RST), .miss(miss), .req_addr(req_addr),
        .victim_way(victim_way), .victim_valid(victim_valid),
        .victim_dirty(victim_dirty), .victim_tag(victim_tag),
        .victim_word0(victim_word0), .victim_word1(victim_word1),
        .mem(mem),
        .fill_en(fill_en), .fill_way(fill_way), .fill_off(fill_off),
        .fill_data(fill_data), .fill_tag(fill_tag), .tag_wen(tag_wen),
        .busy(busy), .done(done), .halt(halt),
        .flush_idx(flush_idx), .flush_way(flush_way), .flushed(flushed)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [68:0] got,
                         input logic [68:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [68:0] ev(input logic [2:0] k, input logic w,
                                       input logic o, input logic [31:0] a,
                                       input logic [31:0] d);
        return {k, w, o, a, d};
    endfunction

    task automatic observe(input logic [68:0] e);
        if (sbq.size() == 0) check("unexpected_event", e, 69'd0);
        else                 check("event", e, sbq.pop_front());
    endtask

    // memory model: stall each request wait_cycles cycles, then accept
    always @(posedge CLK) begin
        #1;
        if (mem.dREN || mem.dWEN) begin
            if (wcnt < wait_cycles) begin
                mem.dwait = 1'b1;
                wcnt++;
            end else begin
                mem.dwait = 1'b0;
                wcnt = 0;
            end
        end else begin
            mem.dwait = 1'b0;
            wcnt = 0;
        end
    end

    logic        pend = 1'b0, p_ren = 1'b0, p_wen = 1'b0;
    logic [31:0] p_addr = '0;

    always @(negedge CLK) begin
        if (pend)
            check("hold", 69'({mem.dREN, mem.dWEN, mem.daddr}),
                  69'({p_ren, p_wen, p_addr}));
        if (mem.dREN || mem.dWEN)
            check("excl", 69'(mem.dREN & mem.dWEN), 69'd0);
        if (mem.dWEN && !mem.dwait)
            observe(ev(K_WR, 1'b0, 1'b0, mem.daddr, mem.dstore));
        if (mem.dREN && !mem.dwait)
            observe(ev(K_RD, 1'b0, 1'b0, mem.daddr, 32'd0));
        if (fill_en)
            observe(ev(K_FL, fill_way, fill_off, 32'd0, fill_data));
        if (tag_wen) begin
            observe(ev(K_TG, fill_way, 1'b0, {6'd0, fill_tag}, 32'd0));
            check("done_with_tag", 69'(done), 69'd1);
        end
        if (done) done_cnt++;
        pend   = (mem.dREN || mem.dWEN) && mem.dwait;
        p_ren  = mem.dREN;
        p_wen  = mem.dWEN;
        p_addr = mem.daddr;
    end

    task automatic run_miss(input logic [31:0] a, input logic way, input logic dirty,
                            input logic [25:0] vt, input logic [31:0] w0,
                            input logic [31:0] w1, input logic [31:0] l0,
                            input logic [31:0] l1, input int waitc,
                            input int pulse_at, input int exp_lat);
        int d0;
        int lat;
        if (dirty) begin
            sbq.push_back(ev(K_WR, 1'b0, 1'b0, {vt, a[5:3], 3'b000}, w0));
            sbq.push_back(ev(K_WR, 1'b0, 1'b0, {vt, a[5:3], 3'b100}, w1));
        end
        sbq.push_back(ev(K_RD, 1'b0, 1'b0, {a[31:3], 3'b000}, 32'd0));
        sbq.push_back(ev(K_FL, way, 1'b0, 32'd0, l0));
        sbq.push_back(ev(K_RD, 1'b0, 1'b0, {a[31:3], 3'b100}, 32'd0));
        sbq.push_back(ev(K_FL, way, 1'b1, 32'd0, l1));
        sbq.push_back(ev(K_TG, way, 1'b0, {6'd0, a[31:6]}, 32'd0));
        wait_cycles = waitc;
        load0 = l0;
        load1 = l1;
        @(negedge CLK);
        drv_addr = a; drv_way = way; drv_valid = 1'b1; drv_dirty = dirty;
        drv_tag = vt; drv_w0 = w0; drv_w1 = w1;
        miss = 1'b1;
        d0 = done_cnt;
        @(posedge CLK);
        #1;
        miss = 1'b0;
        drv_addr = $urandom; drv_way = ~way; drv_tag = 26'($urandom);
        drv_w0 = $urandom; drv_w1 = $urandom; drv_dirty = 1'($urandom);
        lat = 0;
        for (int c = 1; c <= 64; c++) begin
            @(negedge CLK);
            miss = (c == pulse_at);
            if (done) begin
                lat = c;
                break;
            end
        end
        @(posedge CLK);
        #1;
        miss = 1'b0;
        check("latency", 69'(lat), 69'(exp_lat));
        repeat (3) @(negedge CLK);
        check("idle_after", 69'(busy), 69'd0);
        check("one_done", 69'(done_cnt - d0), 69'd1);
        check("sb_drained", 69'(sbq.size()), 69'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int d0;
        mem.dwait = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_bus", 69'({mem.dREN, mem.dWEN, mem.daddr, mem.dstore}), 69'd0);
        check("rst_outs", {fill_en, fill_way, fill_off, fill_data, fill_tag,
                           tag_wen, busy, done, flush_idx, flush_way, flushed}, 69'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        check("post_rst_bus", 69'({mem.dREN, mem.dWEN, mem.daddr}), 69'd0);
        check("post_rst_busy", 69'(busy), 69'd0);

        run_miss(32'h48, 1'b1, 1'b0, 26'h3, 32'h5, 32'h6,
                 32'hAAAA, 32'hBBBB, 0, 0, 3);
        run_miss(32'h88, 1'b0, 1'b1, 26'h1, 32'h11, 32'h22,
                 32'h33, 32'h44, 0, 0, 5);
        run_miss(32'h1234_5670, 1'b1, 1'b0, 26'h7, 32'h1, 32'h2,
                 32'hCAFE_0000, 32'hCAFE_0004, 4, 0, 11);
        run_miss(32'hDEAD_BEE8, 1'b0, 1'b1, 26'h2AB, 32'hF00D, 32'hBEEF,
                 32'h1111, 32'h2222, 0, 2, 5);
        run_miss(32'h0000_0F38, 1'b1, 1'b0, 26'h9, 32'h0, 32'h0,
                 32'h7777, 32'h8888, 0, 3, 3);

        // reset while in FETCH1 abandons the refill
        wait_cycles = 0;
        load0 = 32'h5A5A; load1 = 32'hA5A5;
        sbq.push_back(ev(K_RD, 1'b0, 1'b0, 32'h0000_0100, 32'd0));
        sbq.push_back(ev(K_FL, 1'b1, 1'b0, 32'd0, 32'h5A5A));
        @(negedge CLK);
        drv_addr = 32'h100; drv_way = 1'b1; drv_valid = 1'b1; drv_dirty = 1'b0;
        miss = 1'b1;
        d0 = done_cnt;
        @(posedge CLK);
        #1;
        miss = 1'b0;
        @(posedge CLK);
        #1;
        RST = 1'b1;
        @(negedge CLK);
        check("rst_mid_dren", 69'(mem.dREN), 69'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        check("rst_mid_outs", 69'({mem.dREN, tag_wen, done, busy, fill_en}), 69'd0);
        repeat (3) @(negedge CLK);
        check("rst_mid_nodone", 69'(done_cnt - d0), 69'd0);
        check("rst_mid_sb", 69'(sbq.size()), 69'd0);

        for (int i = 0; i < 6; i++) begin
            logic        dty;
            int          w;
            dty = 1'($urandom);
            w = $urandom_range(0, 2);
            run_miss($urandom, 1'($urandom), dty, 26'($urandom), $urandom,
                     $urandom, $urandom, $urandom, w, 0,
                     (dty ? 4 : 2) * (w + 1) + 1);
        end

`ifdef DCACHE_HALT_FLUSH_EN
        wait_cycles = 1;
        for (int f = 0; f < 2; f++) begin
            logic [2:0] fi;
            logic       fw;
            fi = (f == 0) ? 3'd2 : 3'd5;
            fw = (f == 0);
            sbq.push_back(ev(K_WR, 1'b0, 1'b0, {fr_tag(fi, fw), fi, 3'b000},
                             fr_w0(fi, fw)));
            sbq.push_back(ev(K_WR, 1'b0, 1'b0, {fr_tag(fi, fw), fi, 3'b100},
                             ~fr_w0(fi, fw)));
        end
        @(negedge CLK);
        flush_mode = 1'b1;
        halt = 1'b1;
        miss = 1'b1;
        @(posedge CLK);
        #1;
        halt = 1'b0;
        miss = 1'b0;
        for (int c = 0; c < 200 && !flushed; c++) @(negedge CLK);
        check("flushed", 69'(flushed), 69'd1);
        check("flush_sb", 69'(sbq.size()), 69'd0);
        d0 = done_cnt;
        miss = 1'b1;
        repeat (4) @(negedge CLK);
        miss = 1'b0;
        check("flushed_hold", 69'({flushed, mem.dREN, mem.dWEN}), 69'b100);
        check("flushed_nodone", 69'(done_cnt - d0), 69'd0);
`else
        @(negedge CLK);
        halt = 1'b1;
        repeat (4) @(negedge CLK);
        check("halt_ignored", 69'({busy, flushed, flush_idx, flush_way}), 69'd0);
        halt = 1'b0;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dcache_miss_handler.md
DCACHE_MISS_HANDLER -- requirements
Module: dcache_miss_handler

Interface
REQ-001 SHALL have port CLK, in, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port RST, in, 1, reset, synchronous and active-high.
REQ-003 SHALL have port miss, in, 1, cache lookup miss for current request, sampled in IDLE only.
REQ-004 SHALL have port req_addr, in, 32, missing address: tag [31:6], index [5:3], offset [2], byte [1:0].
REQ-005 SHALL have port victim_way / victim_valid / victim_dirty, in, 1 each, LRU-selected replacement frame and its state bits.
REQ-006 SHALL have port victim_tag, in, 26, tag of victim frame.
REQ-007 SHALL have ports victim_word0 / victim_word1, in, 32 each, victim block words at offset 0 and 1.
REQ-008 SHALL have ports dREN / dWEN, out, 1 each, memory read / write request.
REQ-009 SHALL have ports daddr and dstore, out, 32 each, memory word address and write data.
REQ-010 SHALL have ports dload, in, 32, memory read data; dwait, in, 1, high while memory busy.
REQ-011 SHALL have ports fill_en, out, 1; fill_way, out, 1; fill_off, out, 1; fill_data, out, 32, cache word write.
REQ-012 SHALL have ports fill_tag, out, 26, and tag_wen, out, 1, writing tag with valid=1, dirty=0 into fill_way.
REQ-013 SHALL have ports busy, out, 1 (state != IDLE) and done, out, 1 (one-cycle completion pulse).
REQ-014 SHALL have ports halt, in, 1; flush_idx, out, 3; flush_way, out, 1; flushed, out, 1 (used only under REQ-033).

Function
REQ-015 SHALL implement states IDLE, WB0, WB1, FETCH0, FETCH1, DONE.
REQ-016 SHALL latch req_addr, victim_way, victim_tag, victim_word0/1 on the IDLE-exit edge; later input changes SHALL not affect the transaction.
REQ-017 IDLE: miss & victim_valid & victim_dirty -> WB0; miss otherwise -> FETCH0; else remain.
REQ-018 A memory word transfer SHALL complete in the cycle its request is asserted and dwait=0; request and daddr SHALL hold stable until then.
REQ-019 WB0: dWEN=1, daddr={vtag,idx,1'b0,2'b00}, dstore=word0; on completion -> WB1.
REQ-020 WB1: as WB0 with offset 1, dstore=word1; on completion -> FETCH0.
REQ-021 FETCH0: dREN=1, daddr={rtag,idx,1'b0,2'b00}; on completion fill_en=1, fill_off=0, fill_data=dload, same cycle -> FETCH1.
REQ-022 FETCH1: as FETCH0 with offset 1 -> DONE.
REQ-023 DONE: tag_wen=1, fill_tag=rtag, done=1 for exactly one cycle -> IDLE.
REQ-024 dREN and dWEN SHALL never be high together; both 0 in IDLE and DONE.
REQ-025 fill_way SHALL equal latched victim_way whenever fill_en or tag_wen is high.
REQ-026 miss asserted outside IDLE SHALL be ignored; miss in DONE cycle SHALL not start a transaction until IDLE.
REQ-027 Clean miss latency with dwait=0 SHALL be 3 cycles (FETCH0, FETCH1, DONE); dirty miss 5 cycles.

Reset
REQ-028 RST=1 at a clock edge SHALL force IDLE and clear all latched state.
REQ-029 All outputs SHALL be 0 during and after reset until a new miss.
REQ-030 Reset mid-transaction SHALL abandon it: request deasserted next cycle, no fill_en, tag_wen or done.

Configuration
REQ-031 Macro DCACHE_HALT_FLUSH_EN SHALL control the halt flush feature.
REQ-032 Without it: halt ignored; flush_idx, flush_way, flushed tied 0.
REQ-033 With it: halt in IDLE (priority over miss) -> flush walk over 16 frames (idx 0..7, way 0 then 1 per idx) via states FCHK, FWB0, FWB1.
REQ-034 FCHK: victim_* inputs reflect frame {flush_idx,flush_way}; dirty & valid -> FWB0/FWB1 (same bus rules as WB0/WB1), else advance.
REQ-035 After frame 16: state FLUSHED, flushed=1 held until reset; miss ignored.

Verification
REQ-036 Clean miss, addr 0x0000_0048, dwait=0, dload 0xAAAA/0xBBBB -> dREN daddr 0x48 then 0x4C, fills off0/off1, done at cycle 3.
REQ-037 Dirty miss, vtag 0x1, idx 1, words 0x11/0x22 -> dWEN 0x48=0x11, 0x4C=0x22, then two reads, done cycle 5.
REQ-038 dwait=1 for 4 cycles per transfer -> request and daddr stable throughout; clean done at cycle 11.
REQ-039 RST during FETCH1 -> dREN=0 next cycle, no tag_wen or done, busy=0.
REQ-040 With DCACHE_HALT_FLUSH_EN, frames (2,1) and (5,0) dirty, halt=1 -> exactly 4 writes, ascending, then flushed=1.
REQ-041 miss pulsed during WB1 -> no second transaction; exactly one done.
